// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Shares one 1-cycle-latency ALU between two requesters. Picks one
//            request per cycle (round-robin), drives it onto the ALU bus and
//            steers the returning result into the owner's response FIFO.
//            Credits are reserved at grant, so the FIFOs can never overflow.
// Options  : ALU_ARB_FIXED_PRIO_EN - port 0 always wins a tie (no last ptr)
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        s0_valid,
   output logic        s0_ready,
   input  logic [4:0]  s0_opcode,
   input  logic [2:0]  s0_funct3,
   input  logic [6:0]  s0_funct7,
   input  logic [31:0] s0_opd1,
   input  logic [31:0] s0_opd2,
   input  logic        s1_valid,
   output logic        s1_ready,
   input  logic [4:0]  s1_opcode,
   input  logic [2:0]  s1_funct3,
   input  logic [6:0]  s1_funct7,
   input  logic [31:0] s1_opd1,
   input  logic [31:0] s1_opd2,
   output logic        r0_valid,
   input  logic        r0_ready,
   output logic [31:0] r0_rslt,
   output logic        r1_valid,
   input  logic        r1_ready,
   output logic [31:0] r1_rslt,
   output logic [4:0]  alu_opcode,
   output logic [2:0]  alu_funct3,
   output logic [6:0]  alu_funct7,
   output logic [31:0] alu_opd1,
   output logic [31:0] alu_opd2,
   input  logic [31:0] alu_rslt
);

   localparam int c_aw = $clog2(DEPTH);
   localparam int c_cw = $clog2(DEPTH + 1);
   localparam logic [c_cw-1:0] c_depth = c_cw'(DEPTH);

   logic [1:0]  w_elig;
   logic [1:0]  w_grant;
   logic [1:0]  w_vld;
   logic [1:0]  w_rdy;
   logic [31:0] w_rslt [2];
   logic [c_cw-1:0] w_cnt [2];
   logic        r_fl_v;
   logic        r_fl_port;

   assign w_rdy = {r1_ready, r0_ready};

   // Eligibility uses the registered credit count; a same-cycle pop does not help
   always_comb begin
      w_elig    = 2'b00;
      w_elig[0] = rst & s0_valid & (w_cnt[0] < c_depth);
      w_elig[1] = rst & s1_valid & (w_cnt[1] < c_depth);
   end

`ifdef ALU_ARB_FIXED_PRIO_EN
   // Fixed priority: port 0 wins every tie
   always_comb begin
      w_grant    = 2'b00;
      w_grant[0] = w_elig[0];
      w_grant[1] = w_elig[1] & ~w_elig[0];
   end
`else
   logic r_last;

   // Round-robin: on a tie the port that was not granted last wins
   always_comb begin
      w_grant = w_elig;
      if (&w_elig) begin
         w_grant = r_last ? 2'b01 : 2'b10;
      end
   end

   // Remember the most recently granted port; reset favours port 0
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_last <= 1'b1;
      end else if (|w_grant) begin
         r_last <= w_grant[1];
      end
   end
`endif

   assign s0_ready = w_grant[0];
   assign s1_ready = w_grant[1];

   // Steer the granted request onto the ALU bus; idle bus is all zero
   always_comb begin
      alu_opcode = '0;
      alu_funct3 = '0;
      alu_funct7 = '0;
      alu_opd1   = '0;
      alu_opd2   = '0;
      if (w_grant[0]) begin
         alu_opcode = s0_opcode;
         alu_funct3 = s0_funct3;
         alu_funct7 = s0_funct7;
         alu_opd1   = s0_opd1;
         alu_opd2   = s0_opd2;
      end else if (w_grant[1]) begin
         alu_opcode = s1_opcode;
         alu_funct3 = s1_funct3;
         alu_funct7 = s1_funct7;
         alu_opd1   = s1_opd1;
         alu_opd2   = s1_opd2;
      end
   end

   // Track which port owns the operation currently inside the ALU
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_fl_v    <= 1'b0;
         r_fl_port <= 1'b0;
      end else begin
         r_fl_v    <= |w_grant;
         r_fl_port <= w_grant[1];
      end
   end

   for (genvar k = 0; k < 2; k++) begin : g_port
      logic [c_cw-1:0] r_cnt;
      logic [c_aw:0]   r_wptr;
      logic [c_aw:0]   r_rptr;
      logic [31:0]     r_mem [DEPTH];
      logic            w_wr;
      logic            w_pop;

      assign w_wr      = r_fl_v & (r_fl_port == 1'(k));
      assign w_vld[k]  = (r_wptr != r_rptr);
      assign w_pop     = w_vld[k] & w_rdy[k];
      assign w_rslt[k] = r_mem[r_rptr[c_aw-1:0]];
      assign w_cnt[k]  = r_cnt;

      // Credit counter plus circular FIFO; storage cleared so rslt reads 0 in reset
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_cnt  <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
               r_mem[i] <= '0;
            end
         end else begin
            case ({w_grant[k], w_pop})
               2'b10:   r_cnt <= r_cnt + 1'b1;
               2'b01:   r_cnt <= r_cnt - 1'b1;
               default: r_cnt <= r_cnt;
            endcase
            if (w_wr) begin
               r_mem[r_wptr[c_aw-1:0]] <= alu_rslt;
               r_wptr                  <= r_wptr + 1'b1;
            end
            if (w_pop) begin
               r_rptr <= r_rptr + 1'b1;
            end
         end
      end
   end

   assign r0_valid = w_vld[0];
   assign r1_valid = w_vld[1];
   assign r0_rslt  = w_rslt[0];
   assign r1_rslt  = w_rslt[1];

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Directed self-checking bench for alu_arbiter with a result
//            scoreboard per port and a behavioural 1-cycle ALU.
// Options  : ALU_ARB_FIXED_PRIO_EN - exercises the fixed-priority build
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

`ifdef ALU_ARB_FIXED_PRIO_EN
   localparam int DEPTH = 4;
`else
   localparam int DEPTH = 2;
`endif
   localparam logic [4:0] c_op = 5'b01100;

   logic        clk = 1'b0;
   logic        rst;
   logic        s0_valid, s1_valid, s0_ready, s1_ready;
   logic [4:0]  s0_opcode, s1_opcode, alu_opcode;
   logic [2:0]  s0_funct3, s1_funct3, alu_funct3;
   logic [6:0]  s0_funct7, s1_funct7, alu_funct7;
   logic [31:0] s0_opd1, s0_opd2, s1_opd1, s1_opd2, alu_opd1, alu_opd2;
   logic        r0_valid, r1_valid, r0_ready, r1_ready;
   logic [31:0] r0_rslt, r1_rslt, alu_rslt;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] q0 [$];
   logic [31:0] q1 [$];
   int          k0, k1;
   int          bp_s0 [10] = '{1, 0, 1, 0, 1, 1, 0, 1, 1, 0};
   int          bp_s1 [10] = '{0, 1, 0, 1, 0, 0, 0, 0, 0, 0};

   always #5 clk = ~clk;

   alu_arbiter #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_opcode(s0_opcode),
      .s0_funct3(s0_funct3), .s0_funct7(s0_funct7), .s0_opd1(s0_opd1), .s0_opd2(s0_opd2),
      .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_opcode(s1_opcode),
      .s1_funct3(s1_funct3), .s1_funct7(s1_funct7), .s1_opd1(s1_opd1), .s1_opd2(s1_opd2),
      .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_rslt(r0_rslt),
      .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_rslt(r1_rslt),
      .alu_opcode(alu_opcode), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
      .alu_opd1(alu_opd1), .alu_opd2(alu_opd2), .alu_rslt(alu_rslt)
   );

   // Reference RV32 OP-class ALU
   function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [2:0] f3,
                                           input logic [6:0] f7, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [31:0] r;
      r = '0;
      if (op == c_op) begin
         case (f3)
            3'd0: r = f7[5] ? a - b : a + b;
            3'd1: r = a << b[4:0];
            3'd2: r = {31'b0, $signed(a) < $signed(b)};
            3'd3: r = {31'b0, a < b};
            3'd4: r = a ^ b;
            3'd5: r = f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6: r = a | b;
            default: r = a & b;
         endcase
      end
      return r;
   endfunction

   // External ALU: result one cycle after its inputs
   always @(posedge clk) alu_rslt <= ref_alu(alu_opcode, alu_funct3, alu_funct7, alu_opd1, alu_opd2);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic drv0(input logic v, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b);
      s0_valid = v; s0_opcode = c_op; s0_funct3 = f3; s0_funct7 = f7; s0_opd1 = a; s0_opd2 = b;
   endtask

   task automatic drv1(input logic v, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b);
      s1_valid = v; s1_opcode = c_op; s1_funct3 = f3; s1_funct7 = f7; s1_opd1 = a; s1_opd2 = b;
   endtask

   // Sample at the falling edge: push expected results on accept, compare on pop
   task automatic mon();
      @(negedge clk);
      if (s0_valid && s0_ready) q0.push_back(ref_alu(s0_opcode, s0_funct3, s0_funct7, s0_opd1, s0_opd2));
      if (s1_valid && s1_ready) q1.push_back(ref_alu(s1_opcode, s1_funct3, s1_funct7, s1_opd1, s1_opd2));
      if (r0_valid && r0_ready) begin
         if (q0.size() == 0) chk("r0_spurious_valid", 32'(r0_valid), 0);
         else chk("r0_rslt_order", r0_rslt, q0.pop_front());
      end
      if (r1_valid && r1_ready) begin
         if (q1.size() == 0) chk("r1_spurious_valid", 32'(r1_valid), 0);
         else chk("r1_rslt_order", r1_rslt, q1.pop_front());
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      q0.delete();
      q1.delete();
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic drain(input int n);
      s0_valid = 1'b0;
      s1_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         mon();
         adv();
      end
   endtask

   initial begin
      // Reset state, with requests pending to show ready is held low
      rst = 1'b0;
      r0_ready = 1'b1;
      r1_ready = 1'b1;
      drv0(1'b1, 3'd0, 7'd0, 32'd5, 32'd7);
      drv1(1'b1, 3'd0, 7'd0, 32'd1, 32'd1);
      mon();
      chk("rst_s0_ready", 32'(s0_ready), 0);
      chk("rst_s1_ready", 32'(s1_ready), 0);
      chk("rst_r0_valid", 32'(r0_valid), 0);
      chk("rst_r1_valid", 32'(r1_valid), 0);
      chk("rst_r0_rslt", r0_rslt, 0);
      chk("rst_r1_rslt", r1_rslt, 0);
      chk("rst_alu_opd1", alu_opd1, 0);
      chk("rst_alu_opcode", 32'(alu_opcode), 0);
      drv0(1'b0, 3'd0, 7'd0, 32'd0, 32'd0);
      drv1(1'b0, 3'd0, 7'd0, 32'd0, 32'd0);
      adv();
      rst = 1'b1;
      adv();

      // Single ADD on port 0: 5 + 7
      drv0(1'b1, 3'd0, 7'd0, 32'd5, 32'd7);
      mon();
      chk("add_s0_ready", 32'(s0_ready), 1);
      chk("add_s1_ready", 32'(s1_ready), 0);
      chk("add_alu_opcode", 32'(alu_opcode), 32'(c_op));
      chk("add_alu_opd1", alu_opd1, 5);
      chk("add_alu_opd2", alu_opd2, 7);
      adv();
      s0_valid = 1'b0;
      mon();
      chk("add_r0_valid_t1", 32'(r0_valid), 0);
      chk("add_alu_idle", alu_opd1, 0);
      adv();
      mon();
      chk("add_r0_valid_t2", 32'(r0_valid), 1);
      chk("add_r0_rslt", r0_rslt, 12);
      adv();
      mon();
      chk("add_r0_valid_t3", 32'(r0_valid), 0);
      chk("add_r1_valid", 32'(r1_valid), 0);
      adv();

`ifndef ALU_ARB_FIXED_PRIO_EN
      // Round-robin with both ports continuously requesting
      do_reset();
      k0 = 0;
      k1 = 0;
      for (int i = 0; i < 8; i++) begin
         drv0(1'b1, 3'd0, 7'd0, 32'(100 + k0), 32'd1);
         drv1(1'b1, 3'd0, 7'd0, 32'(200 + k1), 32'd1);
         mon();
         chk("rr_s0_ready", 32'(s0_ready), 32'(i % 2 == 0));
         chk("rr_s1_ready", 32'(s1_ready), 32'(i % 2 == 1));
         if (s0_ready) k0++;
         if (s1_ready) k1++;
         adv();
      end
      drain(4);

      // Backpressure on port 1. The credit round trip is three cycles, so with
      // two entries port 0 alone sustains two grants out of every three cycles.
      do_reset();
      r1_ready = 1'b0;
      k0 = 0;
      k1 = 0;
      for (int c = 0; c < 10; c++) begin
         drv0(1'b1, 3'd0, 7'd0, 32'(300 + k0), 32'd1);
         drv1(1'b1, 3'd0, 7'd0, 32'(400 + k1), 32'd1);
         mon();
         chk("bp_s0_ready", 32'(s0_ready), 32'(bp_s0[c]));
         chk("bp_s1_ready", 32'(s1_ready), 32'(bp_s1[c]));
         if (s0_ready) k0++;
         if (s1_ready) k1++;
         adv();
      end
      s0_valid = 1'b0;
      r1_ready = 1'b1;
      mon();
      chk("bp_r1_valid_first", 32'(r1_valid), 1);
      chk("bp_s1_ready_on_pop", 32'(s1_ready), 0);
      adv();
      mon();
      chk("bp_r1_valid_second", 32'(r1_valid), 1);
      chk("bp_s1_ready_after_pop", 32'(s1_ready), 1);
      adv();
      drain(5);
`else
      // Fixed priority: port 0 takes every tie
      do_reset();
      k0 = 0;
      k1 = 0;
      for (int i = 0; i < 10; i++) begin
         drv0(1'b1, 3'd0, 7'd0, 32'(500 + k0), 32'd1);
         drv1(1'b1, 3'd0, 7'd0, 32'(600 + k1), 32'd1);
         mon();
         chk("fp_s0_ready", 32'(s0_ready), 1);
         chk("fp_s1_ready", 32'(s1_ready), 0);
         if (s0_ready) k0++;
         if (s1_ready) k1++;
         adv();
      end
      s0_valid = 1'b0;
      mon();
      chk("fp_s1_ready_alone", 32'(s1_ready), 1);
      adv();
      drain(5);
`endif

      // Reset pulled in the cycle after a grant
      drv0(1'b1, 3'd0, 7'd0, 32'd9, 32'd9);
      mon();
      chk("mr_s0_ready", 32'(s0_ready), 1);
      adv();
      s0_valid = 1'b0;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         mon();
         chk("mr_r0_valid", 32'(r0_valid), 0);
         chk("mr_r1_valid", 32'(r1_valid), 0);
         adv();
      end
      drv0(1'b1, 3'd0, 7'd0, 32'd11, 32'd22);
      drv1(1'b1, 3'd0, 7'd0, 32'd33, 32'd44);
      mon();
      chk("mr_tie_s0_ready", 32'(s0_ready), 1);
      chk("mr_tie_s1_ready", 32'(s1_ready), 0);
      adv();
      s0_valid = 1'b0;
      mon();
      chk("mr_s1_ready", 32'(s1_ready), 1);
      adv();
      drain(4);

      // SUB on port 1, bus visible only during the grant cycle
      drv1(1'b1, 3'd0, 7'h20, 32'd3, 32'd5);
      mon();
      chk("sub_s1_ready", 32'(s1_ready), 1);
      chk("sub_alu_funct7", 32'(alu_funct7), 32'h20);
      chk("sub_alu_funct3", 32'(alu_funct3), 0);
      chk("sub_alu_opd1", alu_opd1, 3);
      chk("sub_alu_opd2", alu_opd2, 5);
      adv();
      s1_valid = 1'b0;
      mon();
      chk("sub_alu_funct7_idle", 32'(alu_funct7), 0);
      chk("sub_alu_opd2_idle", alu_opd2, 0);
      adv();
      mon();
      chk("sub_r1_valid", 32'(r1_valid), 1);
      chk("sub_r1_rslt", r1_rslt, 32'hFFFFFFFE);
      adv();

      // SRA on port 1, checked through the scoreboard
      drv1(1'b1, 3'd5, 7'h20, 32'h80000000, 32'd4);
      mon();
      chk("sra_s1_ready", 32'(s1_ready), 1);
      adv();
      drain(4);

      chk("sb_q0_empty", 32'(q0.size()), 0);
      chk("sb_q1_empty", 32'(q1.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
